// File: rtl/irq_gateway.sv
// Purpose : per-source IRQ gateway (sync, level/edge capture, enable, pend/serve tracking) feeding the PLIC.
// Latency : irq_in rise -> sources bit after SYNC_STAGES+1 clocks; sources -> top_id/irq_any +1 clock.
// Backpr. : none; claim/complete strobes act as the handshake, so a source stays pending until claimed.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   irq_in[NUM_SRC]          raw peripheral lines (asynchronous); irq_in[k] is source ID k+1
//   irq_en[NUM_SRC]          per-source enable, gates entry into the pending state only
//   claim_en/claim_id        PLIC claim strobe and ID
//   complete_en/complete_id  handler completion strobe and ID
//   sources[NUM_SRC+1]       pending vector to the PLIC, bit 0 tied low
//   irq_any                  registered OR of sources
//   top_id                   registered lowest pending ID, 0 when nothing is pending
module irq_gateway #(
    parameter int                 NUM_SRC     = 31,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0,
    parameter int                 ID_W        = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               claim_en,
    input  logic [ID_W-1:0]    claim_id,
    input  logic               complete_en,
    input  logic [ID_W-1:0]    complete_id,
    output logic [NUM_SRC:0]   sources,
    output logic               irq_any,
    output logic [ID_W-1:0]    top_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SERV = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers and edge history
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] prev_d;
    logic [NUM_SRC-1:0] sync_s;
    logic [NUM_SRC-1:0] req;

    always_comb begin
        sync_d[0] = irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign prev_d = sync_s;

    // Edge sources see a one-cycle pulse on the synchronised rise; level
    // sources request for as long as the synchronised line is high.
    assign req = (sync_s & ~prev_q & EDGE_MASK) | (sync_s & ~EDGE_MASK);

    // ------------------------------------------------------------------
    // Per-source request state
    // ------------------------------------------------------------------
    state_e             state_q [NUM_SRC];
    state_e             state_d [NUM_SRC];
    logic [NUM_SRC-1:0] defer_q;
    logic [NUM_SRC-1:0] defer_d;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] cmp_hit;
    logic [NUM_SRC-1:0] edge_req;
    logic [NUM_SRC-1:0] pend;

    // ID 0 and IDs above NUM_SRC never match any source, so they fall out
    // as no-ops without an explicit range check.
    always_comb begin
        claim_hit = '0;
        cmp_hit   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            claim_hit[k] = claim_en    && (claim_id    == ID_W'(k + 1));
            cmp_hit[k]   = complete_en && (complete_id == ID_W'(k + 1));
        end
    end

    // An enabled edge request that arrives while the source cannot accept
    // it directly; only these are remembered in the deferred flag.
    assign edge_req = EDGE_MASK & req & irq_en;

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            state_d[k] = state_q[k];
            defer_d[k] = defer_q[k];
            case (state_q[k])
                ST_IDLE: begin
                    // A request while disabled is simply lost.
                    if (req[k] && irq_en[k]) begin
                        state_d[k] = ST_PEND;
                    end
                end
                ST_PEND: begin
                    // Further requests merge into the pending one. A claim in
                    // the same cycle as a new edge still serves the old one and
                    // keeps the new edge as deferred.
                    if (claim_hit[k]) begin
                        state_d[k] = ST_SERV;
                        if (edge_req[k]) begin
                            defer_d[k] = 1'b1;
                        end
                    end
                end
                ST_SERV: begin
                    if (cmp_hit[k]) begin
                        // Deferred edge goes straight back to pending; a level
                        // line re-pends naturally from IDLE one cycle later.
                        state_d[k] = (defer_q[k] || edge_req[k]) ? ST_PEND : ST_IDLE;
                        defer_d[k] = 1'b0;
                    end else if (edge_req[k]) begin
                        defer_d[k] = 1'b1;
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    defer_d[k] = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pend = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pend[k] = (state_q[k] == ST_PEND);
        end
    end

    // Decoded directly from the state flops so a new pend is visible to the
    // PLIC in the same cycle the state register updates.
    assign sources = {pend, 1'b0};

    // ------------------------------------------------------------------
    // Summary outputs
    // ------------------------------------------------------------------
    logic            irq_any_q;
    logic            irq_any_d;
    logic [ID_W-1:0] top_id_q;
    logic [ID_W-1:0] top_id_d;

    always_comb begin
        irq_any_d = |sources;
        top_id_d  = '0;
        // Scan downwards so the lowest pending ID is the last one written.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (sources[k+1]) begin
                top_id_d = ID_W'(k + 1);
            end
        end
    end

    assign irq_any = irq_any_q;
    assign top_id  = top_id_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                state_q[k] <= ST_IDLE;
            end
            prev_q    <= '0;
            defer_q   <= '0;
            irq_any_q <= 1'b0;
            top_id_q  <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                state_q[k] <= state_d[k];
            end
            prev_q    <= prev_d;
            defer_q   <= defer_d;
            irq_any_q <= irq_any_d;
            top_id_q  <= top_id_d;
        end
    end

endmodule

// File: tb/tb_irq_gateway.sv
// Purpose : directed bench for irq_gateway; stimulus queues expected outputs, a monitor compares them.
// Latency : expectations are tagged with the clock count at which they must hold.
// Backpr. : none; the monitor samples every falling edge.
module tb_irq_gateway;

    localparam int NUM_SRC = 31;
    localparam int ID_W    = 6;

    logic               clk;
    logic               rst;
    logic [NUM_SRC-1:0] irq_in;
    logic [NUM_SRC-1:0] irq_en;
    logic               claim_en;
    logic [ID_W-1:0]    claim_id;
    logic               complete_en;
    logic [ID_W-1:0]    complete_id;
    logic [NUM_SRC:0]   sources;
    logic               irq_any;
    logic [ID_W-1:0]    top_id;

    irq_gateway #(
        .NUM_SRC    (NUM_SRC),
        .SYNC_STAGES(2),
        .EDGE_MASK  (31'h0000_000C),
        .ID_W       (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .irq_en     (irq_en),
        .claim_en   (claim_en),
        .claim_id   (claim_id),
        .complete_en(complete_en),
        .complete_id(complete_id),
        .sources    (sources),
        .irq_any    (irq_any),
        .top_id     (top_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              due;
        logic [NUM_SRC:0] src;
        logic            any;
        logic [ID_W-1:0] top;
        string           name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic done     = 1'b0;

    // Monitor: compares every expectation that falls due on this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.due < cyc) begin
                failures++;
                $display("FAIL %s: checked late at cycle %0d, required cycle %0d", e.name, cyc, e.due);
            end else if (sources !== e.src || irq_any !== e.any || top_id !== e.top) begin
                failures++;
                $display("FAIL %s: sources=%h irq_any=%0d top_id=%0d, required sources=%h irq_any=%0d top_id=%0d",
                         e.name, sources, irq_any, top_id, e.src, e.any, e.top);
            end
        end
        if (done) begin
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL %s: never checked, cycle now %0d, required cycle %0d", e.name, cyc, e.due);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int d, input logic [NUM_SRC:0] src, input logic any,
                             input logic [ID_W-1:0] top, input string name);
        exp_t e;
        e.due  = cyc + d;
        e.src  = src;
        e.any  = any;
        e.top  = top;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic claim(input int id);
        claim_en = 1'b1;
        claim_id = ID_W'(id);
        tick();
        claim_en = 1'b0;
        claim_id = '0;
    endtask

    task automatic complete(input int id);
        complete_en = 1'b1;
        complete_id = ID_W'(id);
        tick();
        complete_en = 1'b0;
        complete_id = '0;
    endtask

    initial begin
        rst         = 1'b1;
        irq_in      = '0;
        irq_en      = 31'h7FFF_FFF7;   // source 4 disabled
        claim_en    = 1'b0;
        claim_id    = '0;
        complete_en = 1'b0;
        complete_id = '0;
        irq_in[0]   = 1'b1;            // level source 1 high from reset release
        tick(3);
        expect_at(0, 32'h0, 1'b0, 6'd0, "in_reset");

        // ---- level source 1 ----
        rst = 1'b0;
        expect_at(0, 32'h0, 1'b0, 6'd0, "rst_release");
        expect_at(2, 32'h0, 1'b0, 6'd0, "lvl_not_yet");
        expect_at(3, 32'h2, 1'b0, 6'd0, "lvl_pend");
        expect_at(4, 32'h2, 1'b1, 6'd1, "lvl_top");
        tick(4);
        claim(1);
        expect_at(0, 32'h0, 1'b1, 6'd1, "claim1_src");
        expect_at(1, 32'h0, 1'b0, 6'd0, "claim1_top");
        tick();
        complete(1);
        expect_at(0, 32'h0, 1'b0, 6'd0, "compl1_idle");
        expect_at(1, 32'h2, 1'b0, 6'd0, "repend1");
        expect_at(2, 32'h2, 1'b1, 6'd1, "repend1_top");
        tick(2);
        claim(1);                       // source 1 left in service
        expect_at(1, 32'h0, 1'b0, 6'd0, "src1_serv");
        tick();

        // ---- edge source 3 ----
        irq_in[2] = 1'b1;
        tick(2);
        irq_in[2] = 1'b0;
        expect_at(1, 32'h8, 1'b0, 6'd0, "edge3_pend");
        tick();
        irq_in[2] = 1'b1;               // second pulse while pending
        tick(2);
        irq_in[2] = 1'b0;
        tick(3);
        expect_at(0, 32'h8, 1'b1, 6'd3, "edge3_merge");
        claim(3);
        expect_at(0, 32'h0, 1'b1, 6'd3, "claim3");
        expect_at(1, 32'h0, 1'b0, 6'd0, "claim3_none");
        tick(3);
        expect_at(0, 32'h0, 1'b0, 6'd0, "merged_dropped");
        irq_in[2] = 1'b1;               // pulse during service
        tick(2);
        irq_in[2] = 1'b0;
        tick(2);
        expect_at(0, 32'h0, 1'b0, 6'd0, "defer_hidden");
        complete(3);
        expect_at(0, 32'h8, 1'b0, 6'd0, "defer_pend");
        expect_at(1, 32'h8, 1'b1, 6'd3, "defer_top");
        tick();
        claim(3);
        tick();
        complete(3);
        tick(2);
        expect_at(0, 32'h0, 1'b0, 6'd0, "edge3_done");

        // ---- priority between level sources 2 and 5 ----
        irq_in[4] = 1'b1;
        irq_in[1] = 1'b1;
        tick(4);
        expect_at(0, 32'h24, 1'b1, 6'd2, "two_pend");
        claim(2);
        expect_at(0, 32'h20, 1'b1, 6'd2, "claim2_src");
        expect_at(1, 32'h20, 1'b1, 6'd5, "top5");
        tick();
        claim(5);
        expect_at(0, 32'h0, 1'b1, 6'd5, "claim5_src");
        expect_at(1, 32'h0, 1'b0, 6'd0, "top0");
        tick();
        irq_in[4] = 1'b0;
        tick(3);
        complete(5);
        complete(2);
        tick();
        expect_at(0, 32'h4, 1'b0, 6'd0, "repend2");
        // Claim 2 and complete 1 in the same cycle.
        claim_en    = 1'b1;
        claim_id    = 6'd2;
        complete_en = 1'b1;
        complete_id = 6'd1;
        tick();
        claim_en    = 1'b0;
        complete_en = 1'b0;
        claim_id    = '0;
        complete_id = '0;
        expect_at(0, 32'h0, 1'b1, 6'd2, "clm_cmp_src");
        expect_at(1, 32'h2, 1'b0, 6'd0, "clm_cmp_repend1");
        tick();

        // ---- disabled source 4 and invalid IDs ----
        irq_in[3] = 1'b1;
        tick(2);
        irq_in[3] = 1'b0;
        tick(4);
        expect_at(0, 32'h2, 1'b1, 6'd1, "dis4_ignored");
        claim(0);
        claim(40);
        claim(4);                       // idle source
        claim(2);                       // source already in service
        complete(3);                    // idle source
        expect_at(0, 32'h2, 1'b1, 6'd1, "bad_ids");
        tick();

        // ---- asynchronous reset mid-operation ----
        irq_in[1] = 1'b0;
        irq_in[5] = 1'b1;               // level source 6
        claim(1);
        tick(3);
        expect_at(0, 32'h40, 1'b1, 6'd6, "pre_rst");
        expect_at(1, 32'h0, 1'b0, 6'd0, "async_rst");
        tick();
        #2 rst = 1'b1;                  // asserted well away from any edge
        tick();
        rst = 1'b0;
        expect_at(2, 32'h0, 1'b0, 6'd0, "post_rst_wait");
        expect_at(3, 32'h42, 1'b0, 6'd0, "post_rst_repend");
        expect_at(4, 32'h42, 1'b1, 6'd1, "post_rst_top");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            tick();
        end
        done = 1'b1;
    end

endmodule
